// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, instruction field positions and fetch FSM states.
package cpu_pkg;

  localparam logic [3:0] OP_HALT  = 4'b0000;
  localparam logic [3:0] OP_TYPEA = 4'b1111;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int MDIV_MSB   = 1;
  localparam int MDIV_LSB   = 0;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,  // nothing outstanding
    ST_WAIT = 2'd1,  // one read outstanding, response will be used
    ST_DROP = 2'd2,  // one read outstanding, response will be discarded
    ST_HALT = 2'd3
  } fetch_state_t;

  function automatic logic is_halt(input logic [15:0] word);
    return word[OPCODE_MSB:OPCODE_LSB] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry pending register that catches a returned instruction word when IF/ID cannot take it.
module fetch_skid_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  drain,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] addr
);

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values; the
  // payload is reset as well (cheap at one entry) so a flushed buffer never exposes X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      addr  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      // load wins over drain: the old entry moves to IF/ID while the new one takes its place
      valid <= 1'b1;
      data  <= load_data;
      addr  <= load_addr;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem reads, IF/ID register with skid entry,
// stall / redirect / HALT handling.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  PC_STEP     = 2
) (
  input  logic                   clk,
  input  logic                   rstN,
  output logic                   imemReq,
  output logic [PC_WIDTH-1:0]    imemAddr,
  input  logic                   imemValid,
  input  logic [INSTR_WIDTH-1:0] imemData,
  input  logic                   stall,
  input  logic                   redirectValid,
  input  logic [PC_WIDTH-1:0]    redirectTarget,
  output logic                   instrValid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pcOut,
  output logic [3:0]             opcode,
  output logic [1:0]             multiDiv,
  output logic                   halted
);

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

  fetch_state_t             state_q, state_d;
  logic [PC_WIDTH-1:0]      pc_q, pc_d;
  logic [PC_WIDTH-1:0]      req_pc_q;
  logic                     issue;
  logic                     accept;
  logic                     ifid_free;
  logic                     to_ifid;
  logic                     pend_load;
  logic                     pend_drain;
  logic                     pend_valid;
  logic                     pend_valid_next;
  logic [INSTR_WIDTH-1:0]   pend_instr;
  logic [PC_WIDTH-1:0]      pend_pc;

  // A response is only used while a live request is outstanding and no redirect kills it.
  assign accept     = (state_q == ST_WAIT) && imemValid && !redirectValid;
  assign ifid_free  = !instrValid || !stall;
  assign to_ifid    = accept && ifid_free && !pend_valid;
  assign pend_load  = accept && !to_ifid;
  assign pend_drain = ifid_free && pend_valid;
  assign pend_valid_next = !redirectValid && (pend_load || (pend_valid && !pend_drain));

  fetch_skid_buf #(
    .DATA_WIDTH(INSTR_WIDTH),
    .ADDR_WIDTH(PC_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rstN),
    .load     (pend_load),
    .drain    (pend_drain),
    .flush    (redirectValid),
    .load_data(imemData),
    .load_addr(req_pc_q),
    .valid    (pend_valid),
    .data     (pend_instr),
    .addr     (pend_pc)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    issue   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (redirectValid) begin
          pc_d = redirectTarget;
        end else if (!pend_valid) begin
          issue   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirectValid) begin
          pc_d    = redirectTarget;
          state_d = imemValid ? ST_RUN : ST_DROP;
        end else if (imemValid) begin
          if (is_halt(imemData)) begin
            state_d = ST_HALT;
          end else if (!pend_valid_next) begin
            issue = 1'b1;  // back-to-back request keeps a 1-cycle memory fully busy
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DROP: begin
        if (redirectValid) pc_d = redirectTarget;
        if (imemValid) state_d = ST_RUN;
      end
      ST_HALT: begin
        if (redirectValid) begin
          pc_d    = redirectTarget;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (issue) pc_d = pc_q + STEP;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (issue) req_pc_q <= pc_q;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      instrValid <= 1'b0;
      instr      <= '0;
      pcOut      <= '0;
    end else if (redirectValid) begin
      instrValid <= 1'b0;
    end else if (ifid_free) begin
      if (pend_valid) begin
        instrValid <= 1'b1;
        instr      <= pend_instr;
        pcOut      <= pend_pc;
      end else if (to_ifid) begin
        instrValid <= 1'b1;
        instr      <= imemData;
        pcOut      <= req_pc_q;
      end else begin
        instrValid <= 1'b0;
      end
    end
  end

  // Request is held off while reset is asserted; the FSM is already in RUN at release.
  assign imemReq  = issue && rstN;
  assign imemAddr = pc_q;
  assign opcode   = instr[OPCODE_MSB:OPCODE_LSB];
  assign multiDiv = instr[MDIV_MSB:MDIV_LSB];
  assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run scored against
// a program-order model of the delivered instruction stream.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemValid = 1'b0;
  logic [15:0] imemData = '0;
  logic        stall = 1'b0;
  logic        redirectValid = 1'b0;
  logic [15:0] redirectTarget = '0;
  logic        instrValid;
  logic [15:0] instr;
  logic [15:0] pcOut;
  logic [3:0]  opcode;
  logic [1:0]  multiDiv;
  logic        halted;

  fetch_unit dut (
    .clk           (clk),
    .rstN          (rstN),
    .imemReq       (imemReq),
    .imemAddr      (imemAddr),
    .imemValid     (imemValid),
    .imemData      (imemData),
    .stall         (stall),
    .redirectValid (redirectValid),
    .redirectTarget(redirectTarget),
    .instrValid    (instrValid),
    .instr         (instr),
    .pcOut         (pcOut),
    .opcode        (opcode),
    .multiDiv      (multiDiv),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;

  // instruction memory model, word-indexed by addr[8:1]
  logic [15:0] mem [0:255];
  int          lat = 1;
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [15:0] mem_addr = '0;
  logic        last_req = 1'b0;
  logic [15:0] last_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample this cycle's request, advance memory, land #1 after the edge.
  task automatic tick();
    #2;
    last_req  = imemReq;
    last_addr = imemAddr;
    if (imemReq === 1'b1) begin
      check("single_outstanding", {31'b0, mem_busy}, 32'd0);
      mem_busy = 1'b1;
      mem_addr = imemAddr;
      mem_cnt  = lat;
    end
    @(posedge clk);
    #1;
    imemValid = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imemValid = 1'b1;
        imemData  = mem[mem_addr[8:1]];
        mem_busy  = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input bit check_zero);
    rstN = 1'b0;
    stall = 1'b0;
    redirectValid = 1'b0;
    #1;
    if (check_zero) begin
      check("rst_instrValid", instrValid, 0);
      check("rst_instr", instr, 0);
      check("rst_pcOut", pcOut, 0);
      check("rst_imemReq", imemReq, 0);
      check("rst_halted", halted, 0);
    end
    repeat (3) @(posedge clk);
    #1;
    mem_busy  = 1'b0;
    // stale late response carrying a HALT word; must be ignored in RUN
    imemValid = 1'b1;
    imemData  = 16'h0000;
    rstN = 1'b1;
  endtask

  logic [15:0] exp_instr [0:2];
  logic [15:0] exp_pc_tab [0:2];
  logic [3:0]  exp_op [0:2];
  logic [1:0]  exp_md [0:2];

  initial begin
    logic [15:0] exp_pc;
    logic [15:0] prev_instr;
    logic [15:0] prev_pc;
    logic [15:0] w;
    bit          prev_hold;
    int          delivered;

    for (int i = 0; i < 256; i++) mem[i] = 16'h9000 | 16'(i);
    mem[0]  = 16'hF001;
    mem[1]  = 16'h1234;
    mem[2]  = 16'h2005;
    mem[3]  = 16'h0000;
    mem[8]  = 16'h5A03;
    mem[16] = 16'h6C02;
    mem[32] = 16'h7ABC;
    exp_instr  = '{16'hF001, 16'h1234, 16'h2005};
    exp_pc_tab = '{16'h0000, 16'h0002, 16'h0004};
    exp_op     = '{4'hF, 4'h1, 4'h2};
    exp_md     = '{2'd1, 2'd0, 2'd1};

    #1;
    // ---- streaming with a 1-cycle memory, then HALT at 0x0006 and restart ----
    lat = 1;
    do_reset(1'b1);
    tick();
    check("first_req", last_req, 1);
    check("first_addr", last_addr, 16'h0000);
    check("stale_ignored", instrValid, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("stream_valid", instrValid, 1);
      check("stream_instr", instr, exp_instr[k]);
      check("stream_pc", pcOut, exp_pc_tab[k]);
      check("stream_opcode", opcode, exp_op[k]);
      check("stream_multidiv", multiDiv, exp_md[k]);
      tick();
    end
    check("halt_no_req", last_req, 0);
    check("halt_instr", instr, 16'h0000);
    check("halt_pc", pcOut, 16'h0006);
    check("halt_opcode", opcode, 4'h0);
    check("halted_set", halted, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("halt_idle_req", last_req, 0);
      check("halt_held", halted, 1);
    end
    redirectValid = 1'b1;
    redirectTarget = 16'h0010;
    tick();
    redirectValid = 1'b0;
    check("unhalt", halted, 0);
    tick();
    check("unhalt_req", last_req, 1);
    check("unhalt_addr", last_addr, 16'h0010);
    tick();
    check("unhalt_valid", instrValid, 1);
    check("unhalt_instr", instr, 16'h5A03);
    check("unhalt_pc", pcOut, 16'h0010);

    // ---- stall 3 cycles with 0x1234 in IF/ID ----
    do_reset(1'b0);
    repeat (3) tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("stall_valid", instrValid, 1);
      check("stall_instr", instr, 16'h1234);
      check("stall_pc", pcOut, 16'h0002);
      tick();
      check("stall_no_req", last_req, 0);
    end
    stall = 1'b0;
    check("unstall_instr", instr, 16'h1234);
    tick();
    check("drain_no_req", last_req, 0);
    check("pend_instr", instr, 16'h2005);
    check("pend_pc", pcOut, 16'h0004);
    tick();
    check("resume_req", last_req, 1);
    check("resume_addr", last_addr, 16'h0006);
    tick();
    check("order_instr", instr, 16'h0000);
    check("order_pc", pcOut, 16'h0006);
    check("order_halted", halted, 1);

    // ---- 3-cycle memory, redirect during WAIT, then reset mid-WAIT ----
    lat = 3;
    do_reset(1'b0);
    tick();
    check("slow_first_addr", last_addr, 16'h0000);
    redirectValid = 1'b1;
    redirectTarget = 16'h0040;
    tick();
    redirectValid = 1'b0;
    check("drop_no_req0", last_req, 0);
    for (int k = 0; k < 2; k++) begin
      check("drop_invalid", instrValid, 0);
      tick();
      check("drop_no_req", last_req, 0);
    end
    tick();
    check("redir_req", last_req, 1);
    check("redir_addr", last_addr, 16'h0040);
    for (int k = 0; k < 3; k++) begin
      check("redir_wait_invalid", instrValid, 0);
      tick();
    end
    check("redir_valid", instrValid, 1);
    check("redir_instr", instr, 16'h7ABC);
    check("redir_pc", pcOut, 16'h0040);
    do_reset(1'b1);

    // ---- redirect and stall together with pending full ----
    lat = 1;
    do_reset(1'b0);
    tick();
    tick();
    stall = 1'b1;
    tick();
    redirectValid = 1'b1;
    redirectTarget = 16'h0020;
    check("rs_before_instr", instr, 16'hF001);
    tick();
    redirectValid = 1'b0;
    check("rs_flushed", instrValid, 0);
    stall = 1'b0;
    tick();
    check("rs_pend_cleared_req", last_req, 1);
    check("rs_req_addr", last_addr, 16'h0020);
    tick();
    check("rs_new_instr", instr, 16'h6C02);
    check("rs_new_pc", pcOut, 16'h0020);

    // ---- randomized run scored in program order ----
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'h0) w[15:12] = 4'hF;
      mem[i] = w;
    end
    do_reset(1'b0);
    exp_pc = 16'h0000;
    prev_hold = 1'b0;
    prev_instr = '0;
    prev_pc = '0;
    delivered = 0;
    for (int c = 0; c < 800; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirectValid = ($urandom_range(0, 14) == 0);
      redirectTarget = ($urandom_range(0, 7) == 0) ? 16'hFFFC : 16'($urandom_range(0, 127) * 2);
      lat = int'($urandom_range(1, 3));
      if (prev_hold) begin
        check("rnd_hold_valid", instrValid, 1);
        check("rnd_hold_instr", instr, prev_instr);
        check("rnd_hold_pc", pcOut, prev_pc);
      end
      if (redirectValid) begin
        exp_pc = redirectTarget;
      end else if (instrValid && !stall) begin
        check("rnd_pc", pcOut, exp_pc);
        check("rnd_instr", instr, mem[exp_pc[8:1]]);
        exp_pc = exp_pc + 16'd2;
        delivered++;
      end
      prev_hold  = instrValid && stall && !redirectValid;
      prev_instr = instr;
      prev_pc    = pcOut;
      tick();
    end
    redirectValid = 1'b0;
    stall = 1'b0;
    check("rnd_progress", {31'b0, delivered > 100}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
